// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared compare-code constants and search state encoding
package cmp_pkg;

  localparam int CODE_W       = 5;
  localparam int CODE_GT      = 2;
  localparam int CODE_EQ      = 1;
  localparam int CODE_LT      = 0;
  localparam int CODE_RSVD_HI = 4;
  localparam int CODE_RSVD_LO = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sar_search_if.sv
// rtl/sar_search_if.sv - probe/code handshake between search engine and comparator
interface sar_search_if
  import cmp_pkg::*;
#(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0]  probe;
  logic              probe_vld;
  logic [CODE_W-1:0] code;
  logic              code_vld;

  modport master (output probe, output probe_vld, input code, input code_vld);
  modport slave  (input probe, input probe_vld, output code, output code_vld);
endinterface

// File: rtl/sar_code_check.sv
// rtl/sar_code_check.sv - decode comparator code into gt/eq/lt and flag illegal codes
module sar_code_check
  import cmp_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic              gt_o,
  output logic              eq_o,
  output logic              lt_o,
  output logic              illegal_o
);

  logic one_hot;

  always_comb begin
    gt_o      = code_i[CODE_GT];
    eq_o      = code_i[CODE_EQ];
    lt_o      = code_i[CODE_LT];
    // odd parity excludes 0 and 2 bits set; the AND term excludes all 3
    one_hot   = (gt_o ^ eq_o ^ lt_o) && !(gt_o && eq_o && lt_o);
    illegal_o = (code_i[CODE_RSVD_HI:CODE_RSVD_LO] != '0) || !one_hot;
  end

endmodule

// File: rtl/sar_search.sv
// rtl/sar_search.sv - binary search of a hidden target through an external comparator
module sar_search
  import cmp_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_ITER = WIDTH + 1
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  sar_search_if.master     cmp,
  output logic             busy_o,
  output logic             done_o,
  output logic             found_o,
  output logic             err_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] iter_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d, probe_q, probe_d;
  logic [WIDTH-1:0] iter_q, iter_d, result_q, result_d;
  logic             found_q, found_d, err_q, err_d;
  logic [WIDTH-1:0] nlo, nhi;
  logic [WIDTH:0]   mid_sum;
  logic             bad;
  logic             gt, eq, lt, illegal;

  sar_code_check u_check (
    .code_i    (cmp.code),
    .gt_o      (gt),
    .eq_o      (eq),
    .lt_o      (lt),
    .illegal_o (illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '1;
      probe_q  <= '0;
      iter_q   <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      probe_q  <= probe_d;
      iter_q   <= iter_d;
      result_q <= result_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    probe_d  = probe_q;
    iter_d   = iter_q;
    result_d = result_q;
    found_d  = found_q;
    err_d    = err_q;
    nlo      = lo_q;
    nhi      = hi_q;
    mid_sum  = '0;
    bad      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          mid_sum = {1'b0, {WIDTH{1'b0}}} + {1'b0, {WIDTH{1'b1}}};
          lo_d    = '0;
          hi_d    = '1;
          probe_d = mid_sum[WIDTH:1];
          iter_d  = WIDTH'(1);
          found_d = 1'b0;
          err_d   = 1'b0;
          state_d = PROBE;
        end
      end
      PROBE: begin
        if (cmp.code_vld) begin
          if (illegal) begin
            bad = 1'b1;
          end else if (eq) begin
            result_d = probe_q;
            found_d  = 1'b1;
            state_d  = DONE;
          end else begin
            if (gt) begin
              if (probe_q == '1) bad = 1'b1;
              else nlo = probe_q + WIDTH'(1);
            end else if (lt) begin
              if (probe_q == '0) bad = 1'b1;
              else nhi = probe_q - WIDTH'(1);
            end
            if (nlo > nhi || iter_q == WIDTH'(MAX_ITER)) bad = 1'b1;
            if (!bad) begin
              // sum kept WIDTH+1 bits wide so lo+hi near the top cannot wrap
              mid_sum = {1'b0, nlo} + {1'b0, nhi};
              lo_d    = nlo;
              hi_d    = nhi;
              probe_d = mid_sum[WIDTH:1];
              iter_d  = iter_q + WIDTH'(1);
            end
          end
          if (bad) begin
            found_d = 1'b0;
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o        = 1'b0;
    done_o        = 1'b0;
    cmp.probe_vld = 1'b0;
    case (state_q)
      PROBE: begin
        busy_o        = 1'b1;
        cmp.probe_vld = 1'b1;
      end
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  assign cmp.probe = probe_q;
  assign found_o   = found_q;
  assign err_o     = err_q;
  assign result_o  = result_q;
  assign iter_o    = iter_q;

endmodule
